// File: rtl/spi_led_pkg.sv
// spi_led_pkg: shared encodings for the SPI register-mapped LED controller
package spi_led_pkg;
    localparam logic [1:0] MODE_OFF   = 2'b00;
    localparam logic [1:0] MODE_ON    = 2'b01;
    localparam logic [1:0] MODE_BLINK = 2'b10;
    localparam logic [1:0] MODE_PWM   = 2'b11;
    localparam logic [6:0] ADDR_ID    = 7'h00;
    localparam logic [6:0] ADDR_CTRL  = 7'h01;
    localparam logic [6:0] ADDR_CH0   = 7'h02;
    localparam int         HDR_WR_BIT = 7;
    localparam logic [7:0] CTRL_RST   = 8'h01;
    typedef enum logic {ST_IDLE, ST_DATA} state_t;
endpackage

// File: rtl/spi_led_if.sv
// spi_led_if: byte-level link between spi_slave and the LED register file
interface spi_led_if;
    logic [7:0] cmd;
    logic       cmd_valid;
    logic       frame_active;
    logic [7:0] response;
    modport master (output cmd, cmd_valid, frame_active, input response);
    modport slave  (input cmd, cmd_valid, frame_active, output response);
endinterface

// File: rtl/led_channel.sv
// led_channel: one registered LED output from its mode/level register
module led_channel
    import spi_led_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] ch_reg,
    input  logic [5:0] pwm_cnt,
    input  logic       blink,
    input  logic       en,
    output logic       led
);
    logic led_d, led_q;
    always_comb begin
        led_d = en && ((ch_reg[7:6] == MODE_ON) ||
                       (ch_reg[7:6] == MODE_BLINK && blink) ||
                       (ch_reg[7:6] == MODE_PWM && pwm_cnt < ch_reg[5:0]));
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) led_q <= 1'b0;
        else     led_q <= led_d;
    end
    assign led = led_q;
endmodule

// File: rtl/spi_led_ctrl.sv
// spi_led_ctrl: SPI-framed register file driving per-channel off/on/blink/PWM LEDs
module spi_led_ctrl
    import spi_led_pkg::*;
#(
    parameter int         N_CH    = 4,
    parameter int         PRESC_W = 8,
    parameter int         BLINK_W = 8,
    parameter int         HB_W    = 25,
    parameter logic [7:0] ID_BYTE = 8'hA8
) (
    input  logic            clk,
    input  logic            rst,
    spi_led_if.slave        bus,
    output logic [N_CH-1:0] led,
    output logic            heartbeat
);
    state_t             state_d, state_q;
    logic [6:0]         addr_d, addr_q, pend_addr_d, pend_addr_q;
    logic               wr_d, wr_q, pend_d, pend_q;
    logic [7:0]         resp_d, resp_q, ctrl_d, ctrl_q, pend_data_d, pend_data_q;
    logic [7:0]         ch_d [N_CH];
    logic [7:0]         ch_q [N_CH];
    logic [PRESC_W-1:0] presc_d, presc_q;
    logic [5:0]         pwm_d, pwm_q;
    logic [BLINK_W-1:0] blink_d, blink_q;
    logic [HB_W-1:0]    hb_d, hb_q;
    function automatic logic [7:0] reg_rd(input logic [6:0] a);
        logic [7:0] r;
        r = (a == ADDR_ID) ? ID_BYTE : (a == ADDR_CTRL) ? ctrl_q : 8'h00;
        for (int i = 0; i < N_CH; i++) if (a == ADDR_CH0 + 7'(i)) r = ch_q[i];
        return r;
    endfunction
    always_comb begin
        presc_d = presc_q + 1'b1;
        pwm_d   = &presc_q ? pwm_q + 6'd1 : pwm_q;
        blink_d = (&presc_q && &pwm_q) ? blink_q + 1'b1 : blink_q;
        hb_d    = hb_q + 1'b1;
    end
    // Data bytes are staged one cycle before they land in the register file
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wr_d        = wr_q;
        resp_d      = resp_q;
        ctrl_d      = ctrl_q;
        ch_d        = ch_q;
        pend_d      = 1'b0;
        pend_addr_d = pend_addr_q;
        pend_data_d = pend_data_q;
        if (pend_q) begin
            if (pend_addr_q == ADDR_CTRL) ctrl_d = pend_data_q;
            for (int i = 0; i < N_CH; i++) if (pend_addr_q == ADDR_CH0 + 7'(i)) ch_d[i] = pend_data_q;
        end
        if (!bus.frame_active) begin
            state_d = ST_IDLE;
            resp_d  = ID_BYTE;
        end else if (bus.cmd_valid) begin
            if (state_q == ST_IDLE) begin
                wr_d    = bus.cmd[HDR_WR_BIT];
                addr_d  = bus.cmd[6:0];
                resp_d  = bus.cmd[HDR_WR_BIT] ? 8'h00 : reg_rd(bus.cmd[6:0]);
                state_d = ST_DATA;
            end else begin
                pend_d      = wr_q;
                pend_addr_d = addr_q;
                pend_data_d = bus.cmd;
                addr_d      = addr_q + 7'd1;
                resp_d      = reg_rd(addr_q + 7'd1);
            end
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            wr_q        <= 1'b0;
            resp_q      <= ID_BYTE;
            ctrl_q      <= CTRL_RST;
            ch_q        <= '{default: '0};
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            pend_data_q <= '0;
            presc_q     <= '0;
            pwm_q       <= '0;
            blink_q     <= '0;
            hb_q        <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wr_q        <= wr_d;
            resp_q      <= resp_d;
            ctrl_q      <= ctrl_d;
            ch_q        <= ch_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
            pend_data_q <= pend_data_d;
            presc_q     <= presc_d;
            pwm_q       <= pwm_d;
            blink_q     <= blink_d;
            hb_q        <= hb_d;
        end
    end
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        led_channel u_ch (
            .clk     (clk),
            .rst     (rst),
            .ch_reg  (ch_q[i]),
            .pwm_cnt (pwm_q),
            .blink   (blink_q[BLINK_W-1]),
            .en      (ctrl_q[0]),
            .led     (led[i])
        );
    end
    assign bus.response = resp_q;
    assign heartbeat    = hb_q[HB_W-1];
endmodule

// File: tb/tb_spi_led_ctrl.sv
// tb_spi_led_ctrl: frame-level self-checking bench for spi_led_ctrl
module tb_spi_led_ctrl;
    localparam int N_CH = 4;
    logic            clk, rst;
    logic [N_CH-1:0] led;
    logic            heartbeat;
    int              n_chk, n_fail;
    logic [7:0]      exp_q[$];
    spi_led_if bus ();
    spi_led_ctrl #(.N_CH(N_CH), .PRESC_W(2), .BLINK_W(4), .HB_W(6), .ID_BYTE(8'hA8)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .led       (led),
        .heartbeat (heartbeat)
    );
    typedef struct {
        logic [7:0] b0, b1, r0, r1;
        string      name;
    } vec_t;
    vec_t vecs[10];
    initial clk = 1'b0;
    always #5 clk = ~clk;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask
    task automatic xfer(input logic [7:0] b, input logic [7:0] exp, input string nm);
        exp_q.push_back(exp);
        @(negedge clk);
        bus.cmd = b;
        bus.cmd_valid = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: scoreboard empty", nm);
        end else chk(nm, bus.response, exp_q.pop_front());
    endtask
    task automatic frame_begin();
        @(negedge clk);
        bus.frame_active = 1'b1;
        @(negedge clk);
    endtask
    task automatic frame_end();
        @(negedge clk);
        bus.frame_active = 1'b0;
        @(negedge clk);
        chk("end_resp_id", bus.response, 8'hA8);
    endtask
    task automatic count_led(input int idx, input int cycles, output int cnt);
        cnt = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            cnt += int'(led[idx]);
        end
    endtask
    initial begin
        int   c0, c1, c2, c3, k;
        logic h0;
        n_chk = 0;
        n_fail = 0;
        vecs[0] = '{8'h00, 8'h00, 8'hA8, 8'h01, "rd_id"};
        vecs[1] = '{8'h01, 8'h00, 8'h01, 8'h40, "rd_ctrl"};
        vecs[2] = '{8'h02, 8'h00, 8'h40, 8'h00, "rd_ch0"};
        vecs[3] = '{8'h80, 8'h55, 8'h00, 8'h01, "wr_id"};
        vecs[4] = '{8'h00, 8'h00, 8'hA8, 8'h01, "rd_id_ro"};
        vecs[5] = '{8'hFF, 8'h12, 8'h00, 8'hA8, "wr_7f_wrap"};
        vecs[6] = '{8'h7F, 8'h00, 8'h00, 8'hA8, "rd_7f_wrap"};
        vecs[7] = '{8'h81, 8'h03, 8'h00, 8'h40, "wr_ctrl3"};
        vecs[8] = '{8'h01, 8'h00, 8'h03, 8'h40, "rd_ctrl3"};
        vecs[9] = '{8'h81, 8'h01, 8'h00, 8'h40, "wr_ctrl1"};
        bus.cmd = 8'h00;
        bus.cmd_valid = 1'b0;
        bus.frame_active = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_resp", bus.response, 8'hA8);
        chk("rst_led", led, 0);
        chk("rst_hb", heartbeat, 0);
        frame_begin();
        xfer(8'h82, 8'h00, "hdr_w_ch0");
        @(negedge clk);
        bus.cmd = 8'h40;
        bus.cmd_valid = 1'b1;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        chk("led0_T", led[0], 0);
        @(posedge clk);
        #1 chk("led0_T1", led[0], 0);
        @(posedge clk);
        #1 chk("led0_T2", led[0], 1);
        frame_end();
        foreach (vecs[i]) begin
            frame_begin();
            xfer(vecs[i].b0, vecs[i].r0, {vecs[i].name, "_b0"});
            xfer(vecs[i].b1, vecs[i].r1, {vecs[i].name, "_b1"});
            frame_end();
        end
        frame_begin();
        xfer(8'h82, 8'h00, "burst_hdr");
        xfer(8'hC0, 8'h00, "burst_d0");
        xfer(8'hD0, 8'h00, "burst_d1");
        xfer(8'hFF, 8'h00, "burst_d2");
        xfer(8'h80, 8'h00, "burst_d3");
        frame_end();
        repeat (4) @(negedge clk);
        count_led(0, 256, c0);
        chk("pwm_lvl0", c0, 0);
        count_led(1, 256, c1);
        chk("pwm_lvl16", c1, 64);
        count_led(2, 256, c2);
        chk("pwm_lvl63", c2, 252);
        count_led(3, 8192, c3);
        chk("blink_duty", c3, 4096);
        k = 0;
        h0 = heartbeat;
        while (heartbeat == h0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        k = 0;
        h0 = heartbeat;
        while (heartbeat == h0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("hb_half_period", k, 32);
        frame_begin();
        xfer(8'h81, 8'h00, "ctrl_off_hdr");
        xfer(8'h00, 8'hC0, "ctrl_off_d");
        chk("ctrl_off_led", led, 0);
        frame_end();
        frame_begin();
        xfer(8'h03, 8'hD0, "ch1_kept");
        xfer(8'h00, 8'hFF, "ch2_kept");
        frame_end();
        frame_begin();
        xfer(8'h81, 8'h00, "ctrl_on_hdr");
        xfer(8'h01, 8'hC0, "ctrl_on_d");
        frame_end();
        count_led(1, 256, c1);
        chk("restore_lvl16", c1, 64);
        frame_begin();
        xfer(8'h83, 8'h00, "drop_hdr");
        frame_end();
        frame_begin();
        xfer(8'h03, 8'hD0, "new_hdr");
        xfer(8'h00, 8'hFF, "new_d");
        frame_end();
        frame_begin();
        xfer(8'h83, 8'h00, "coinc_hdr");
        @(negedge clk);
        bus.cmd = 8'h00;
        bus.cmd_valid = 1'b1;
        bus.frame_active = 1'b0;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("coinc_resp", bus.response, 8'hA8);
        frame_begin();
        xfer(8'h03, 8'hD0, "coinc_discard");
        frame_end();
        frame_begin();
        xfer(8'h82, 8'h00, "rst_burst_hdr");
        xfer(8'h41, 8'hD0, "rst_burst_d0");
        xfer(8'h41, 8'hFF, "rst_burst_d1");
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_led", led, 0);
        chk("midrst_resp", bus.response, 8'hA8);
        @(negedge clk);
        rst = 1'b0;
        xfer(8'h02, 8'h00, "postrst_hdr");
        xfer(8'h00, 8'h00, "postrst_d");
        frame_end();
        frame_begin();
        xfer(8'h01, 8'h01, "postrst_ctrl");
        xfer(8'h00, 8'h00, "postrst_ch0");
        frame_end();
        chk("postrst_led", led, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
